// File: rtl/hd_secded_packer_pkg.sv
// Shared constants and types for the SECDED packet packer.
//   - Codeword geometry: 16-bit word, overall parity at bit 0, Hamming
//     parity at bits 1/2/4/8. The other 11 bits carry data.
//   - Priority field location inside the corrected control word.
//   - Queue slot geometry: 16-bit slots, PACK_W/16 of them.
//   - FSM state encoding for the packer.
package hd_secded_packer_pkg;

    localparam int CW_W      = 16;    // codeword width (only 16 is supported)
    localparam int PRIO_W    = 3;     // priority field width
    localparam int PORT_W    = 4;     // port field width, reserved
    localparam int PACK_W    = 1024;  // packed queue word width
    localparam int DATA_BITS = 11;    // decoded data bits per codeword
    localparam int SYN_W     = 4;     // syndrome width

    // Parity bit positions inside a codeword
    localparam int POS_OVERALL = 0;
    localparam int POS_P1      = 1;
    localparam int POS_P2      = 2;
    localparam int POS_P4      = 4;
    localparam int POS_P8      = 8;

    // Priority field inside the corrected control codeword
    localparam int PRIO_LSB = 8;
    localparam int PRIO_MSB = 10;

    // Queue slot geometry; the slot counter has one extra bit so it can
    // represent "buffer full" (== SLOT_NUM).
    localparam int SLOT_W     = 16;
    localparam int SLOT_NUM   = PACK_W / SLOT_W;
    localparam int SLOT_IDX_W = $clog2(SLOT_NUM) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CTRL    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Zero-extends an 11-bit decoded data value into one queue slot.
    function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_BITS-1:0] d);
        return {{(SLOT_W - DATA_BITS){1'b0}}, d};
    endfunction

endpackage

// File: rtl/hd_secded_packer_if.sv
// Write-side bus and packed-result bus of the SECDED packer.
//   wr_sop   : start-of-packet marker cycle (wr_data ignored)
//   wr_eop   : end-of-packet marker cycle (wr_data ignored)
//   wr_vld   : wr_data qualifier
//   wr_data  : SECDED codeword
//   Queue    : packed decoded payload, 16-bit slots
//   prior    : packet priority
//   data_vld : one-cycle packet-complete strobe
//   error    : packet contained an uncorrectable word (or was malformed)
// master = packet source / result consumer, slave = packer.
interface hd_secded_packer_if
    import hd_secded_packer_pkg::*;
#(
    parameter int DATA_WIDTH   = CW_W,
    parameter int PRIORITY_BIT = PRIO_W,
    parameter int DATAPACK_BIT = PACK_W
);
    logic                    wr_sop;
    logic                    wr_eop;
    logic                    wr_vld;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATAPACK_BIT-1:0] Queue;
    logic [PRIORITY_BIT-1:0] prior;
    logic                    data_vld;
    logic                    error;

    modport master (
        output wr_sop, wr_eop, wr_vld, wr_data,
        input  Queue, prior, data_vld, error
    );

    modport slave (
        input  wr_sop, wr_eop, wr_vld, wr_data,
        output Queue, prior, data_vld, error
    );
endinterface

// File: rtl/hd_secded_packer_secded16_decode.sv
// Combinational Hamming SECDED decoder for one 16-bit codeword.
//   i_cw         : received codeword
//   o_corr       : codeword with a single-bit error repaired (unchanged
//                  for clean or double-error words)
//   o_data11     : data bits {c15..c9, c7..c5, c3} of o_corr
//   o_single_err : a single-bit error was corrected
//   o_double_err : uncorrectable double-bit error
module secded16_decode
    import hd_secded_packer_pkg::*;
(
    input  logic [CW_W-1:0]      i_cw,
    output logic [CW_W-1:0]      o_corr,
    output logic [DATA_BITS-1:0] o_data11,
    output logic                 o_single_err,
    output logic                 o_double_err
);

    logic [SYN_W-1:0] w_syn;
    logic             w_par;

    always_comb begin
        // Syndrome = XOR of the indices of all set bits 1..15; for a single
        // flipped bit it equals that bit's index.
        w_syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (i_cw[i]) begin
                w_syn = w_syn ^ SYN_W'(i);
            end
        end
        w_par = ^i_cw;

        o_single_err = w_par;
        o_double_err = !w_par && (w_syn != '0);

        // Odd overall parity means exactly one flip; syndrome 0 then points
        // at the overall parity bit itself.
        o_corr = i_cw;
        if (w_par) begin
            o_corr[w_syn] = ~o_corr[w_syn];
        end

        o_data11 = {o_corr[CW_W-1:POS_P8+1],
                    o_corr[POS_P8-1:POS_P4+1],
                    o_corr[POS_P4-1:POS_P2+1]};
    end

endmodule

// File: rtl/hd_secded_packer.sv
// SECDED packet packer: decodes a framed packet of 16-bit SECDED
// codewords, takes the priority from the control word and packs the
// decoded payload into a 1024-bit queue word.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of hd_secded_packer_if (write bus in, result out)
// Results are published one cycle after the eop marker cycle and held
// until the next packet completes.
module hd_secded_packer
    import hd_secded_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    hd_secded_packer_if.slave bus
);

    state_t                  r_state;
    logic [PACK_W-1:0]       r_buf;
    logic [SLOT_IDX_W-1:0]   r_slot;
    logic                    r_sticky;
    logic [PRIO_W-1:0]       r_prio_lat;
    logic [PACK_W-1:0]       r_queue;
    logic [PRIO_W-1:0]       r_prior;
    logic                    r_error;
    logic                    r_data_vld;

    logic [CW_W-1:0]         w_corr;
    logic [DATA_BITS-1:0]    w_data11;
    logic                    w_single_err;
    logic                    w_double_err;
    logic                    w_unused_bits;

    secded16_decode u_dec (
        .i_cw         (bus.wr_data),
        .o_corr       (w_corr),
        .o_data11     (w_data11),
        .o_single_err (w_single_err),
        .o_double_err (w_double_err)
    );

    // Corrections are silent; only the priority bits of the corrected word
    // are needed here.
    assign w_unused_bits = ^{w_single_err, w_corr[CW_W-1:PRIO_MSB+1], w_corr[PRIO_LSB-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_slot     <= '0;
            r_sticky   <= 1'b0;
            r_prio_lat <= '0;
            r_queue    <= '0;
            r_prior    <= '0;
            r_error    <= 1'b0;
            r_data_vld <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            // sop restarts from any state and outranks a simultaneous eop
            if (bus.wr_sop) begin
                r_buf      <= '0;
                r_slot     <= '0;
                r_sticky   <= 1'b0;
                r_prio_lat <= '0;
                r_state    <= ST_CTRL;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_CTRL: begin
                        if (bus.wr_eop) begin
                            // Packet ended without a control word
                            r_queue    <= '0;
                            r_prior    <= '0;
                            r_error    <= 1'b1;
                            r_data_vld <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else if (bus.wr_vld) begin
                            r_prio_lat <= w_corr[PRIO_MSB:PRIO_LSB];
                            if (w_double_err) begin
                                r_sticky <= 1'b1;
                            end
                            r_state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (bus.wr_eop) begin
                            r_queue    <= r_buf;
                            r_prior    <= r_prio_lat;
                            r_error    <= r_sticky;
                            r_data_vld <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else if (bus.wr_vld) begin
                            if (r_slot == SLOT_IDX_W'(SLOT_NUM)) begin
                                // Buffer full: drop the word, flag the packet
                                r_sticky <= 1'b1;
                            end else begin
                                r_buf[r_slot[SLOT_IDX_W-2:0] * SLOT_W +: SLOT_W] <= to_slot(w_data11);
                                r_slot <= r_slot + SLOT_IDX_W'(1);
                                if (w_double_err) begin
                                    r_sticky <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Queue    = r_queue;
    assign bus.prior    = r_prior;
    assign bus.error    = r_error;
    assign bus.data_vld = r_data_vld;

endmodule

// File: tb/tb_hd_secded_packer.sv
// Bench for hd_secded_packer: hand-derived vector table, directed
// multi-cycle sequences and randomized packets against a reference model.
module tb_hd_secded_packer;
    import hd_secded_packer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hd_secded_packer_if bus_if ();

    hd_secded_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // Builds a valid codeword from 11 data bits.
    function automatic logic [15:0] enc(input logic [10:0] d);
        logic [15:0] cw;
        logic        p;
        int          k;
        cw = '0;
        k  = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (((i >> j) & 1) == 1) p = p ^ cw[i];
            end
            cw[1 << j] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] ext(input logic [15:0] cw);
        logic [10:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

    function automatic bit is_valid(input logic [15:0] cw);
        return enc(ext(cw)) == cw;
    endfunction

    // Nearest-codeword search: clean, one flip away, or neither (double).
    task automatic model_dec(input logic [15:0] cw, output logic [15:0] corr, output bit dbl);
        logic [15:0] t;
        bit          found;
        corr  = cw;
        dbl   = 1'b0;
        found = is_valid(cw);
        for (int b = 0; b < 16; b++) begin
            t = cw;
            t[b] = ~t[b];
            if (!found && is_valid(t)) begin
                corr  = t;
                found = 1'b1;
            end
        end
        if (!found) dbl = 1'b1;
    endtask

    function automatic logic [15:0] corrupt(input logic [15:0] cw, input int nflip);
        logic [15:0] r;
        int          a;
        int          b;
        r = cw;
        a = $urandom_range(0, 15);
        if (nflip >= 1) r[a] = ~r[a];
        if (nflip >= 2) begin
            b = $urandom_range(0, 15);
            while (b == a) b = $urandom_range(0, 15);
            r[b] = ~r[b];
        end
        return r;
    endfunction

    function automatic int pick_flips();
        int rr;
        rr = $urandom_range(0, 9);
        return (rr < 7) ? 0 : ((rr < 9) ? 1 : 2);
    endfunction

    // ---------------- checkers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [PACK_W-1:0] act, input logic [PACK_W-1:0] exp);
        int s;
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            s = 0;
            while (s < SLOT_NUM - 1 && act[s*16 +: 16] === exp[s*16 +: 16]) s++;
            $display("FAIL %s: slot %0d got 0x%04h, expected 0x%04h", name, s,
                     act[s*16 +: 16], exp[s*16 +: 16]);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.wr_sop  = 1'b0;
        bus_if.wr_eop  = 1'b0;
        bus_if.wr_vld  = 1'b0;
        bus_if.wr_data = 16'($urandom);
    endtask

    task automatic do_sop();
        bus_if.wr_sop  = 1'b1;
        bus_if.wr_vld  = 1'($urandom);
        bus_if.wr_data = 16'($urandom);
        cyc();
        idle_inputs();
    endtask

    task automatic do_word(input logic [15:0] cw);
        bus_if.wr_vld  = 1'b1;
        bus_if.wr_data = cw;
        cyc();
        idle_inputs();
    endtask

    task automatic do_gap();
        idle_inputs();
        cyc();
    endtask

    task automatic do_eop();
        bus_if.wr_eop  = 1'b1;
        bus_if.wr_vld  = 1'($urandom);
        bus_if.wr_data = 16'($urandom);
        cyc();
        idle_inputs();
    endtask

    // Called right after the eop cycle: checks the strobe and results,
    // then that the strobe drops and the results hold.
    task automatic chk_pkt(input string name, input logic [PACK_W-1:0] eq,
                           input logic [2:0] ep, input logic ee);
        chk({name, "_dv"}, 32'(bus_if.data_vld), 32'd1);
        chk({name, "_prior"}, 32'(bus_if.prior), 32'(ep));
        chk({name, "_err"}, 32'(bus_if.error), 32'(ee));
        chk_q({name, "_queue"}, bus_if.Queue, eq);
        cyc();
        chk({name, "_dv_drop"}, 32'(bus_if.data_vld), 32'd0);
        chk_q({name, "_queue_hold"}, bus_if.Queue, eq);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [15:0]       ctrl;
        logic [2:0]        n;
        logic [3:0][15:0]  pay;
        logic              gap;
        logic [2:0]        prior;
        logic              err;
        logic [3:0][15:0]  slot;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] c, input int n,
                                input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                                input logic gap, input logic [2:0] pr, input logic er,
                                input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
        vec_t v;
        v       = '0;
        v.ctrl  = c;
        v.n     = 3'(n);
        v.pay[0] = p0;
        v.pay[1] = p1;
        v.pay[2] = p2;
        v.gap   = gap;
        v.prior = pr;
        v.err   = er;
        v.slot[0] = s0;
        v.slot[1] = s1;
        v.slot[2] = s2;
        return v;
    endfunction

    vec_t vecs[8];

    logic [PACK_W-1:0] eq;
    logic [15:0]       words[72];
    logic [15:0]       corr;
    bit                dbl;
    logic [2:0]        ep;
    logic              ee;
    int                nw;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(16'h0505, 2, 16'hFFFF, 16'h0000, 16'h0, 1'b0, 3'b101, 1'b0, 16'h07FF, 16'h0000, 16'h0);
        vecs[1] = mk(16'h0505, 1, 16'hFFDF, 16'h0, 16'h0, 1'b0, 3'b101, 1'b0, 16'h07FF, 16'h0, 16'h0);
        vecs[2] = mk(16'h0501, 1, 16'hFFFF, 16'h0, 16'h0, 1'b0, 3'b101, 1'b0, 16'h07FF, 16'h0, 16'h0);
        vecs[3] = mk(16'h0505, 1, 16'hFFF9, 16'h0, 16'h0, 1'b0, 3'b101, 1'b1, 16'h07FF, 16'h0, 16'h0);
        vecs[4] = mk(16'h0505, 1, 16'h0000, 16'h0, 16'h0, 1'b0, 3'b101, 1'b0, 16'h0000, 16'h0, 16'h0);
        vecs[5] = mk(16'h0505, 2, 16'hFFFF, 16'h0000, 16'h0, 1'b1, 3'b101, 1'b0, 16'h07FF, 16'h0000, 16'h0);
        vecs[6] = mk(16'h0506, 1, 16'hFFFF, 16'h0, 16'h0, 1'b0, 3'b101, 1'b1, 16'h07FF, 16'h0, 16'h0);
        vecs[7] = mk(16'h0505, 3, 16'hFFFF, 16'hFFDF, 16'h0000, 1'b0, 3'b101, 1'b0, 16'h07FF, 16'h07FF, 16'h0000);

        // Reset
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_queue", 32'(bus_if.Queue != '0), 32'd0);
        chk("rst_prior", 32'(bus_if.prior), 32'd0);
        chk("rst_error", 32'(bus_if.error), 32'd0);
        chk("rst_dv", 32'(bus_if.data_vld), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Table-driven packets
        for (int v = 0; v < 8; v++) begin
            do_sop();
            do_word(vecs[v].ctrl);
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                do_word(vecs[v].pay[j]);
                if (vecs[v].gap && j == 0) do_gap();
            end
            chk($sformatf("vec%0d_dv_pre", v), 32'(bus_if.data_vld), 32'd0);
            do_eop();
            eq = '0;
            for (int j = 0; j < 4; j++) eq[j*16 +: 16] = vecs[v].slot[j];
            chk_pkt($sformatf("vec%0d", v), eq, vecs[v].prior, vecs[v].err);
        end

        // Abort by a second sop: only the second packet is reported
        do_sop();
        do_word(16'h0505);
        do_word(16'hFFFF);
        do_sop();
        chk("abort_dv", 32'(bus_if.data_vld), 32'd0);
        do_word(16'h0505);
        do_word(enc(11'h0AA));
        do_eop();
        eq = '0;
        eq[15:0] = 16'h00AA;
        chk_pkt("abort", eq, 3'b101, 1'b0);

        // sop and eop together mid-packet: sop wins, no output
        do_sop();
        do_word(16'h0505);
        do_word(16'h0000);
        bus_if.wr_sop = 1'b1;
        bus_if.wr_eop = 1'b1;
        cyc();
        idle_inputs();
        chk("sopeop_dv", 32'(bus_if.data_vld), 32'd0);
        do_word(16'h0505);
        do_word(16'hFFFF);
        do_eop();
        eq = '0;
        eq[15:0] = 16'h07FF;
        chk_pkt("sopeop", eq, 3'b101, 1'b0);

        // Overflow: 65 payload words
        do_sop();
        do_word(16'h0505);
        eq = '0;
        for (int j = 0; j < 65; j++) begin
            words[j] = enc(11'($urandom));
            if (j < 64) eq[j*16 +: 16] = {5'b0, ext(words[j])};
            do_word(words[j]);
        end
        do_eop();
        chk_pkt("overflow", eq, 3'b101, 1'b1);

        // eop with no control word
        do_sop();
        do_eop();
        chk_pkt("eop_ctrl", '0, 3'b000, 1'b1);

        // eop in IDLE: no strobe, results held
        do_eop();
        chk("eop_idle_dv", 32'(bus_if.data_vld), 32'd0);
        chk("eop_idle_err_hold", 32'(bus_if.error), 32'd1);

        // Reset mid-packet discards it
        do_sop();
        do_word(16'h0505);
        do_word(16'hFFFF);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_queue", 32'(bus_if.Queue != '0), 32'd0);
        chk("midrst_err", 32'(bus_if.error), 32'd0);
        do_eop();
        chk("midrst_eop_dv", 32'(bus_if.data_vld), 32'd0);

        // Randomized packets against the model
        for (int p = 0; p < 30; p++) begin
            words[0] = corrupt(enc(11'($urandom)), pick_flips());
            model_dec(words[0], corr, dbl);
            ep = corr[10:8];
            ee = dbl;
            nw = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 8);
            eq = '0;
            for (int j = 0; j < nw; j++) begin
                words[j+1] = corrupt(enc(11'($urandom)), pick_flips());
                model_dec(words[j+1], corr, dbl);
                if (j < SLOT_NUM) begin
                    eq[j*16 +: 16] = {5'b0, ext(corr)};
                    if (dbl) ee = 1'b1;
                end else begin
                    ee = 1'b1;
                end
            end
            do_sop();
            if ($urandom_range(0, 3) == 0) do_gap();
            do_word(words[0]);
            for (int j = 0; j < nw; j++) begin
                if ($urandom_range(0, 4) == 0) do_gap();
                do_word(words[j+1]);
            end
            do_eop();
            chk_pkt($sformatf("rnd%0d", p), eq, ep, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hd_secded_packer.md
Name: hd_secded_packer

Overview:
- Receives framed packets of 16-bit Hamming SECDED codewords on a write interface.
- Corrects single-bit errors and detects double-bit errors.
- Extracts a priority field from the first (control) word and packs the decoded payload into a 1024-bit queue word.
- Sits at the front of the SRAM controller ingress path and feeds the queue/priority to the storage scheduler.

Parameters:
- DATA_WIDTH, 16, codeword width (fixed 16; other values unsupported).
- PRIORITY_BIT, 3, width of the priority field.
- PORT_BIT, 4, port field width (reserved, unused by the logic).
- DATAPACK_BIT, 1024, width of the packed Queue output (64 slots of 16 bits).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_sop  in  1  start-of-packet marker cycle; wr_data ignored that cycle.
- wr_eop  in  1  end-of-packet marker cycle; wr_data ignored that cycle.
- wr_vld  in  1  wr_data valid qualifier.
- wr_data  in  DATA_WIDTH  SECDED codeword.
- Queue  out  DATAPACK_BIT  packed decoded payload.
- prior  out  PRIORITY_BIT  packet priority.
- data_vld  out  1  one-cycle packet-complete strobe.
- error  out  1  packet contained an uncorrectable word.

Behaviour:
- Codeword format: bit 0 is overall parity (even over all 16 bits); bits 1, 2, 4, 8 are Hamming parity; data bits are 3, 5, 6, 7, 9–15.
- Syndrome s[3:0]: XOR of indices i (1..15) where bit i = 1. Overall parity p: XOR of all 16 bits.
- Classification:
  - p=0, s=0: clean.
  - p=1: single error at bit s (s=0 means bit 0); flip that bit.
  - p=0, s≠0: double error, uncorrectable.
- Decoded data is 11 bits: {c15,c14,c13,c12,c11,c10,c9,c7,c6,c5,c3}.
- FSM states IDLE, CTRL, PAYLOAD.
  - Any state, wr_sop=1: clear payload buffer, slot counter and sticky error; go to CTRL. A sop mid-packet aborts that packet with no output.
  - CTRL: first cycle with wr_vld=1 is the control word. Latch prior from corrected codeword bits [10:8]. A double error sets the sticky error. Go to PAYLOAD.
  - PAYLOAD: each cycle with wr_vld=1, wr_sop=0, wr_eop=0 decodes one word and writes {5'b0, data11} into slot k = Queue[16k+15:16k]. The first payload word goes to slot 0; k increments. A double error sets sticky error. wr_vld=0 cycles are skipped.
  - Overflow: more than 64 payload words sets sticky error; extra words are dropped.
  - wr_eop=1 in PAYLOAD or CTRL: on the next cycle, Queue ← buffer (unused slots 0), prior ← latched priority, error ← sticky error, data_vld=1 for exactly one cycle; go to IDLE.
  - eop arriving in CTRL (no control word received): prior=0, error=1, Queue all 0.
  - eop in IDLE: ignored.
  - wr_sop and wr_eop in the same cycle: sop wins, eop ignored.
- Queue, prior and error hold their values until the next packet completes.
- Reset (rst_n=0 at a clock edge): all outputs 0, FSM to IDLE, buffer cleared. A reset mid-packet discards the packet.
- Latency: data_vld asserts exactly 1 cycle after the eop cycle.

Decomposition:
- Shared package holds:
  - Codeword position constants (parity positions 0, 1, 2, 4, 8).
  - Priority field LSB/MSB (8/10).
  - Slot width 16 and slot count DATAPACK_BIT/16.
  - FSM state enum.
- One combinational sub-module, secded16_decode: input codeword; outputs corrected codeword, data11, single_err, double_err.

Test Plan:
- Reset: rst_n=0 for 2 cycles → Queue=0, prior=0, error=0, data_vld=0.
- Clean packet: sop; ctrl 0x0505; payload 0xFFFF, 0x0000; eop → next cycle data_vld=1, prior=3'b101, error=0, slot0=0x07FF, slot1=0x0000, other slots 0.
- Single-bit correction: ctrl 0x0505, payload 0xFFDF (bit 5 flipped) → slot0=0x07FF, error=0. Ctrl 0x0501 (bit 2 flipped) → prior still 3'b101.
- Double-bit detection: payload 0xFFF9 (bits 1, 2 flipped) → error=1, data_vld=1. The next clean packet gives error=0.
- wr_vld gaps: payload 0xFFFF, idle wr_vld=0 cycle, 0x0000 → only 2 slots written, in order.
- Abort/overflow: second sop mid-packet → no data_vld for the first packet; 65 payload words → error=1, slots 0–63 filled.
